// File: rtl/serial_word_receiver_pkg.sv
// rtl/serial_word_receiver_pkg.sv - shared states and frame constants for the serial word receiver
package serial_word_receiver_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Line idles at 0, so a 1 marks a start and a 0 closes the frame.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    RX_IDLE = ST_IDLE,
    RX_DATA = ST_DATA,
    RX_STOP = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/serial_word_receiver_rx_out_buffer.sv
// rtl/serial_word_receiver_rx_out_buffer.sv - single-entry valid/ready word holder with overrun flag
module rx_out_buffer #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [size-1:0] load_data,
  input  logic            out_ready,
  input  logic            clr_err,
  output logic [size-1:0] data,
  output logic            valid,
  output logic            overrun
);

  logic accept;
  logic drop;

  // A load fits if the slot is empty or its word leaves on this same edge.
  assign accept = load && (!valid || out_ready);
  assign drop   = load && valid && !out_ready;

  // Holding register: load, consume, or keep; the sticky overrun favours set over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && out_ready) begin
        valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - start/data/stop framed serial to parallel receiver
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_en,
  input  logic            srl_in,
  input  logic            msb_first,
  input  logic            clr_err,
  output logic [size-1:0] prl_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun
);

  localparam int CW = $clog2(size);
  localparam logic [CW-1:0] LAST_BIT = CW'(size - 1);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] shreg_q, shreg_d;
  logic            order_q, order_d;
  logic            busy_q;
  logic            frame_err_q;
  logic            load;
  logic            frame_set;

  // Next-state logic; nothing advances except on a bit strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    order_d   = order_q;
    load      = 1'b0;
    frame_set = 1'b0;
    if (bit_en) begin
      case (state_q)
        RX_IDLE: begin
          if (srl_in == START_BIT) begin
            state_d = RX_DATA;
            order_d = msb_first;
            cnt_d   = '0;
          end
        end
        RX_DATA: begin
          // Order is frozen at the start bit so msb_first may change mid-frame.
          if (order_q) begin
            shreg_d = {shreg_q[size-2:0], srl_in};
          end else begin
            shreg_d = {srl_in, shreg_q[size-1:1]};
          end
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = RX_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (srl_in == STOP_BIT) begin
            load = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // State, counter, shifter, busy and sticky framing flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      order_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      order_q <= order_d;
      busy_q  <= (state_d != RX_IDLE);
      if (frame_set) begin
        frame_err_q <= 1'b1;
      end else if (clr_err) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign frame_err = frame_err_q;

  rx_out_buffer #(.size(size)) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (shreg_q),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .data      (prl_out),
    .valid     (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb/tb_serial_word_receiver.sv - randomized bench for serial_word_receiver against a frame-level model
module tb_serial_word_receiver;

  localparam int SIZE = 8;
  localparam int EV_NONE = 0, EV_START = 1, EV_DATA = 2, EV_GOOD = 3, EV_BAD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bit_en = 1'b0;
  logic            srl_in = 1'b0;
  logic            msb_first = 1'b0;
  logic            clr_err = 1'b0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] prl_out;
  logic            out_valid;
  logic            busy;
  logic            frame_err;
  logic            overrun;

  serial_word_receiver #(.size(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .srl_in    (srl_in),
    .msb_first (msb_first),
    .clr_err   (clr_err),
    .prl_out   (prl_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Frame-level expectation of the receiver's visible outputs.
  logic [SIZE-1:0] m_word;
  logic            m_valid, m_busy, m_err, m_ovr;
  logic [SIZE-1:0] m_incoming;
  bit              rand_mode = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the event the bench knows it sent, compare.
  task automatic cyc(input logic be, input logic s, input int ev);
    if (rand_mode) begin
      out_ready = 1'($urandom_range(0, 1));
      clr_err   = ($urandom_range(0, 7) == 0);
      if (ev != EV_START) msb_first = 1'($urandom_range(0, 1));
    end
    bit_en = be;
    srl_in = s;
    @(posedge clk);
    if (rst) begin
      m_word = '0; m_valid = 0; m_busy = 0; m_err = 0; m_ovr = 0;
    end else begin
      logic ovr_set, err_set;
      ovr_set = 0;
      err_set = 0;
      if (be && ev == EV_START) m_busy = 1;
      if (be && ev == EV_BAD) begin m_busy = 0; err_set = 1; end
      if (be && ev == EV_GOOD) begin
        m_busy = 0;
        if (m_valid && !out_ready) ovr_set = 1;
        else begin m_word = m_incoming; m_valid = 1; end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_err = err_set ? 1'b1 : (clr_err ? 1'b0 : m_err);
      m_ovr = ovr_set ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
    end
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("prl_out", 32'(prl_out), 32'(m_word));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic stalls();
    if (rand_mode) begin
      int n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'($urandom_range(0, 1)), EV_NONE);
    end
  endtask

  // Sends start, SIZE data bits of word in the chosen order, then the stop bit.
  // abort_at >= 0 pulses reset in place of that data bit; stop_ready >= 0 forces out_ready at the stop bit.
  task automatic send_frame(input logic [SIZE-1:0] word, input logic order, input logic stopb,
                            input int abort_at, input int stop_ready);
    logic b;
    stalls();
    msb_first = order;
    cyc(1'b1, 1'b1, EV_START);
    for (int i = 0; i < SIZE; i++) begin
      stalls();
      b = order ? word[SIZE-1-i] : word[i];
      if (i == abort_at) begin
        rst = 1;
        cyc(1'b1, b, EV_NONE);
        rst = 0;
        return;
      end
      cyc(1'b1, b, EV_DATA);
    end
    stalls();
    if (stop_ready >= 0) out_ready = (stop_ready != 0);
    m_incoming = word;
    cyc(1'b1, stopb, stopb ? EV_BAD : EV_GOOD);
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, EV_NONE);
  endtask

  initial begin
    // Reset and idle line
    rst = 1;
    cyc(1'b0, 1'b0, EV_NONE);
    cyc(1'b0, 1'b0, EV_NONE);
    rst = 0;
    idle_bits(10);

    // MSB-first 0xAA held until consumed
    out_ready = 0;
    send_frame(8'hAA, 1'b1, 1'b0, -1, -1);
    idle_bits(3);
    out_ready = 1;
    cyc(1'b0, 1'b0, EV_NONE);
    out_ready = 0;

    // LSB-first 0x55 and 0xF0
    send_frame(8'h55, 1'b0, 1'b0, -1, -1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;
    send_frame(8'hF0, 1'b0, 1'b0, -1, -1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;

    // Framing error, clear, then a good frame
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    clr_err = 1; cyc(1'b0, 1'b0, EV_NONE); clr_err = 0;
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;

    // Overrun, then simultaneous consume and load
    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;
    clr_err = 1; cyc(1'b0, 1'b0, EV_NONE); clr_err = 0;
    send_frame(8'h11, 1'b0, 1'b0, -1, -1);
    send_frame(8'h22, 1'b0, 1'b0, -1, 1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;

    // Reset mid-frame and with a word pending, then 0xA5
    send_frame(8'h77, 1'b1, 1'b1, -1, -1);
    send_frame(8'h99, 1'b1, 1'b0, 4, -1);
    send_frame(8'h66, 1'b1, 1'b0, -1, -1);
    rst = 1; cyc(1'b0, 1'b0, EV_NONE); rst = 0;
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    out_ready = 1; cyc(1'b0, 1'b0, EV_NONE); out_ready = 0;

    // Randomized traffic with stalls, mid-frame order changes, random ready/clear
    rand_mode = 1;
    for (int f = 0; f < 60; f++) begin
      logic [SIZE-1:0] w;
      w = SIZE'($urandom);
      send_frame(w, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, SIZE-1)) : -1, -1);
      idle_bits($urandom_range(0, 2));
    end
    rand_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
